// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared FSM states and LFSR step function for the PRBS generator/checker pair
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    localparam int LFSR_MAX_W = 64;

    // One generator step: shift left, feed back the parity of the top 8 bits.
    // Words narrower than LFSR_MAX_W sit in the low bits; callers cast the result down.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] w,
                                                        input int width);
        logic                  fb;
        logic [LFSR_MAX_W-1:0] r;
        fb = 1'b0;
        r  = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if ((i < width) && (i >= width - 8)) begin
                fb = fb ^ w[i];
            end
        end
        for (int i = 1; i < LFSR_MAX_W; i++) begin
            if (i < width) begin
                r[i] = w[i-1];
            end
        end
        r[0] = fb;
        return r;
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-seeding PRBS word checker with lock detection and error counting
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int NUM_LEN  = 10,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic [NUM_LEN-1:0] data_in,
    input  logic               clr_cnt,
    output logic               locked,
    output logic               err,
    output logic [CNT_W-1:0]   err_count
);

    localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    prbs_state_t        state;
    prbs_state_t        state_n;
    logic [NUM_LEN-1:0] pred;
    logic [NUM_LEN-1:0] pred_n;
    logic [RUN_W-1:0]   good_run;
    logic [RUN_W-1:0]   good_n;
    logic [RUN_W-1:0]   bad_run;
    logic [RUN_W-1:0]   bad_n;
    logic               err_n;

    logic [NUM_LEN-1:0] nxt_data;
    logic [NUM_LEN-1:0] nxt_pred;
    logic               word_zero;
    logic               word_match;
    logic               good_last;
    logic               bad_last;

    // Successor of the received word (used for seeding) and of the predictor (flywheel).
    assign nxt_data   = NUM_LEN'(lfsr_next(LFSR_MAX_W'(data_in), NUM_LEN));
    assign nxt_pred   = NUM_LEN'(lfsr_next(LFSR_MAX_W'(pred), NUM_LEN));
    assign word_zero  = (data_in == '0);
    assign word_match = (data_in == pred);
    assign good_last  = (good_run == RUN_W'(LOCK_CNT - 1));
    assign bad_last   = (bad_run == RUN_W'(LOSS_CNT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; only valid words move the FSM.
    always_comb begin
        state_n = state;
        if (valid) begin
            case (state)
                HUNT: begin
                    if (!word_zero) begin
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        if (good_last) begin
                            state_n = LOCKED;
                        end
                    end else if (word_zero) begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (!word_match && bad_last) begin
                        state_n = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // Predictor, run-counter and error-strobe updates for the current word.
    always_comb begin
        pred_n = pred;
        good_n = good_run;
        bad_n  = bad_run;
        err_n  = 1'b0;
        if (valid) begin
            case (state)
                HUNT: begin
                    if (!word_zero) begin
                        pred_n = nxt_data;
                        good_n = '0;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        pred_n = nxt_data;
                        good_n = good_run + RUN_W'(1);
                        if (good_last) begin
                            bad_n = '0;
                        end
                    end else if (!word_zero) begin
                        pred_n = nxt_data;
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    // Once locked the predictor free-runs so a corrupted word cannot poison it.
                    pred_n = nxt_pred;
                    if (word_match) begin
                        bad_n = '0;
                    end else begin
                        err_n = 1'b1;
                        bad_n = bad_run + RUN_W'(1);
                    end
                end
                default: begin
                    pred_n = pred;
                end
            endcase
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred     <= '0;
            good_run <= '0;
            bad_run  <= '0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            pred     <= pred_n;
            good_run <= good_n;
            bad_run  <= bad_n;
            err      <= err_n;
            locked   <= (state_n == LOCKED);
        end
    end

    // Saturating error counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (err_n && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - randomized, model-checked bench for prbs_checker
module tb_prbs_checker;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [9:0]  data_in;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic        locked2;
    logic        err2;
    logic [1:0]  err_count2;

    int checks;
    int passes;

    // Reference model state
    int m_mode;     // 0 = hunting, 1 = verifying, 2 = locked
    int m_pred;
    int m_good;
    int m_bad;
    int m_cnt16;
    int m_cnt2;
    bit m_err;
    bit m_locked;
    bit started;

    prbs_checker #(.NUM_LEN(10), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count)
    );

    prbs_checker #(.NUM_LEN(10), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator step in plain arithmetic: shift within 10 bits, add parity of bits 9..2.
    function automatic int nxt(input int w);
        return ((w << 1) & 1023) | ($countones((w >> 2) & 255) & 1);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: advance on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        int  w;
        bit  mis;
        if (rst) begin
            m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0;
            m_cnt16 = 0; m_cnt2 = 0; m_err = 0; m_locked = 0;
            started = 1;
        end else begin
            mis = 0;
            if (valid) begin
                w = int'(data_in);
                if (m_mode == 0) begin
                    if (w != 0) begin
                        m_pred = nxt(w); m_good = 0; m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (w == m_pred) begin
                        m_pred = nxt(w);
                        m_good = m_good + 1;
                        if (m_good == 4) begin
                            m_mode = 2; m_bad = 0;
                        end
                    end else if (w != 0) begin
                        m_pred = nxt(w); m_good = 0;
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    mis = (w != m_pred);
                    m_pred = nxt(m_pred);
                    if (!mis) m_bad = 0;
                    else begin
                        m_bad = m_bad + 1;
                        if (m_bad == 3) m_mode = 0;
                    end
                end
            end
            m_err = mis;
            if (clr_cnt) begin
                m_cnt16 = 0; m_cnt2 = 0;
            end else if (mis) begin
                if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
            m_locked = (m_mode == 2);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("locked", int'(locked), int'(m_locked));
            chk("err", int'(err), int'(m_err));
            chk("err_count", int'(err_count), m_cnt16);
            chk("locked_w2", int'(locked2), int'(m_locked));
            chk("err_w2", int'(err2), int'(m_err));
            chk("err_count_w2", int'(err_count2), m_cnt2);
        end
    end

    // One cycle of stimulus; returns 2 time units after the sampling edge.
    task automatic drive(input bit v, input int d, input bit c = 1'b0, input bit r = 1'b0);
        valid   = v;
        data_in = d[9:0];
        clr_cnt = c;
        rst     = r;
        @(posedge clk);
        #2;
    endtask

    task automatic good_word();
        drive(1'b1, m_pred);
    endtask

    task automatic bad_word(input bit c = 1'b0);
        drive(1'b1, m_pred ^ 1, c);
    endtask

    int seq[5];

    initial begin
        checks = 0; passes = 0; started = 0;
        rst = 1'b1; valid = 1'b0; data_in = '0; clr_cnt = 1'b0;
        m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0;
        m_cnt16 = 0; m_cnt2 = 0; m_err = 0; m_locked = 0;
        @(posedge clk);
        #2;
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_count", int'(err_count), 0);
        drive(1'b0, 0);

        // Acquire lock from the sequence 1,2,4,9,19
        seq = '{1, 2, 4, 9, 19};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("acq_not_yet", int'(locked), 0);
            drive(1'b1, seq[i]);
        end
        chk("acq_locked", int'(locked), 1);
        chk("acq_count", int'(err_count), 0);

        // Single corruption: 39 matches, 0x3FF replaces 78, 157 matches via flywheel
        drive(1'b1, 39);
        chk("flw_39_err", int'(err), 0);
        drive(1'b1, 10'h3FF);
        chk("corrupt_err", int'(err), 1);
        chk("corrupt_count", int'(err_count), 1);
        drive(1'b1, 157);
        chk("flw_157_err", int'(err), 0);
        chk("flw_157_locked", int'(locked), 1);

        // Loss of lock after three consecutive mismatches
        bad_word(); bad_word();
        chk("loss_still_locked", int'(locked), 1);
        bad_word();
        chk("loss_unlocked", int'(locked), 0);
        chk("loss_count", int'(err_count), 4);

        // Relock with a clean sequence seeded from 5
        drive(1'b1, 5);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("relock_not_yet", int'(locked), 0);
            good_word();
        end
        chk("relock", int'(locked), 1);

        // HUNT/VERIFY robustness
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 0);
        drive(1'b1, 1); drive(1'b1, 2); drive(1'b1, 7);
        for (int i = 0; i < 3; i++) good_word();
        chk("reseed_not_yet", int'(locked), 0);
        good_word();
        chk("reseed_locked", int'(locked), 1);
        chk("reseed_count", int'(err_count), 0);

        // clr_cnt coincident with a locked mismatch
        bad_word();
        good_word();
        bad_word(1'b1);
        chk("clr_err", int'(err), 1);
        chk("clr_count", int'(err_count), 0);

        // Saturation of the narrow counter
        good_word();
        for (int i = 0; i < 5; i++) begin
            bad_word();
            good_word();
        end
        chk("sat_w2", int'(err_count2), 3);
        chk("sat_w16", int'(err_count), 5);

        // Gaps between valid words while acquiring
        drive(1'b0, 0, 1'b0, 1'b1);
        seq = '{1, 2, 4, 9, 19};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i]);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive(1'b0, int'($urandom_range(0, 1023)));
        end
        chk("gap_locked", int'(locked), 1);
        drive(1'b1, 39);
        chk("gap_39_err", int'(err), 0);

        // Reset while locked
        bad_word();
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(err_count), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            int d;
            bit c;
            r = int'($urandom_range(0, 99));
            c = ($urandom_range(0, 99) < 3);
            if (r < 1) drive(1'b0, 0, c, 1'b1);
            else if (r < 25) drive(1'b0, int'($urandom_range(0, 1023)), c);
            else begin
                r = int'($urandom_range(0, 99));
                if (r < 72) d = m_pred;
                else if (r < 80) d = 0;
                else d = int'($urandom_range(0, 1023));
                drive(1'b1, d, c);
            end
        end
        drive(1'b0, 0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
